imem_boot_loader: RTL and testbench

- Byte-stream program loader sitting directly upstream of the MIPS32 SoC instruction memory.
- Receives a framed image from a UART/host byte source and assembles little-endian 32-bit words.
- Writes each word into instruction memory through a word-indexed write port matching the PC[11:2] indexing.
- Holds the CPU in reset until a complete, checksum-verified image is loaded.

---
 rtl/imem_boot_loader.sv | 151 +++++++++++++++
 tb/tb_imem_boot_loader.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: assembles framed little-endian words into instruction memory
// and holds the CPU in reset until a checksum-verified image is in place. Option: BOOT_TIMEOUT_EN.
module imem_boot_loader #(
  parameter int          ADDR_W         = 10,
  parameter int          MAX_WORDS      = 1024,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CHK, S_DONE, S_ERROR
  } state_t;

  state_t              state, state_next;
  logic [7:0]          len_lo;
  logic [15:0]         len;
  logic [1:0]          byte_idx;
  logic [ADDR_W-1:0]   word_idx;
  logic [23:0]         word_buf;
  logic [7:0]          csum;

  logic                accept, is_sync, word_end, last_word, timeout;
  logic                in_ready_d, done_d, cpu_rst_d, error_d, we_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [31:0]         wdata_d;
  logic [ADDR_W:0]     words_d;

  assign accept    = in_valid && in_ready;
  assign is_sync   = (in_data == SYNC_BYTE);
  assign word_end  = (state == S_DATA) && accept && (byte_idx == 2'd3);
  assign last_word = (32'(word_idx) == 32'(len) - 32'd1);

`ifdef BOOT_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        timed;

  assign timed   = (state == S_LEN0) || (state == S_LEN1) || (state == S_DATA) || (state == S_CHK);
  assign timeout = timed && !accept && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !timed || accept) tmo_cnt <= '0;
    else                         tmo_cnt <= tmo_cnt + 32'd1;
  end
`else
  // Always false: the loader waits indefinitely between bytes.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  // State register plus datapath; every register, including the word buffer, is reset.
  // NOTE: sequential state uses non-blocking (<=) so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      len_lo       <= '0;
      len          <= '0;
      byte_idx     <= '0;
      word_idx     <= '0;
      word_buf     <= '0;
      csum         <= '0;
      in_ready     <= 1'b1;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_rst      <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      state        <= state_next;
      in_ready     <= in_ready_d;
      imem_we      <= we_d;
      imem_addr    <= addr_d;
      imem_wdata   <= wdata_d;
      cpu_rst      <= cpu_rst_d;
      done         <= done_d;
      error        <= error_d;
      words_loaded <= words_d;
      if (accept) begin
        case (state)
          S_LEN0: len_lo <= in_data;
          S_LEN1: begin
            len      <= {in_data, len_lo};
            byte_idx <= '0;
            word_idx <= '0;
            csum     <= '0;
          end
          S_DATA: begin
            csum     <= csum ^ in_data;
            word_buf <= {in_data, word_buf[23:8]};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) word_idx <= word_idx + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Next-state logic.
  // NOTE: a default assignment first in each always_comb prevents latch inference.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept && is_sync) state_next = S_LEN0;
      S_LEN0:  if (accept) state_next = S_LEN1;
      S_LEN1:  if (accept) begin
        if ({16'd0, in_data, len_lo} > 32'(MAX_WORDS)) state_next = S_ERROR;
        else if ({in_data, len_lo} == 16'd0)          state_next = S_CHK;
        else                                           state_next = S_DATA;
      end
      S_DATA:  if (word_end && last_word) state_next = S_CHK;
      S_CHK:   if (accept) state_next = (in_data == csum) ? S_DONE : S_ERROR;
      S_DONE:  state_next = S_DONE;
      S_ERROR: if (accept && is_sync) state_next = S_LEN0;
      default: state_next = S_IDLE;
    endcase
    if (timeout) state_next = S_ERROR;
  end

  // Next values of the registered outputs.
  always_comb begin
    in_ready_d = (state_next != S_DONE);
    done_d     = (state_next == S_DONE);
    cpu_rst_d  = (state_next != S_DONE);
    error_d    = (state_next == S_ERROR);
    we_d       = word_end;
    addr_d     = imem_addr;
    wdata_d    = imem_wdata;
    words_d    = words_loaded;
    if (word_end) begin
      addr_d  = word_idx;
      wdata_d = {in_data, word_buf};
      words_d = words_loaded + 1'b1;
    end
    if (accept && is_sync && (state == S_IDLE || state == S_ERROR)) words_d = '0;
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: valid, bad-checksum, resync, zero-length,
// oversize and mid-frame-reset frames, plus the inter-byte timeout when enabled.
module tb_imem_boot_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  int tests_run    = 0;
  int tests_failed = 0;
  int we_count     = 0;
  int we_base      = 0;

  imem_boot_loader #(
    .ADDR_W(ADDR_W), .MAX_WORDS(1024), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_rst(cpu_rst),
    .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (imem_we === 1'b1) we_count++;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One byte per cycle; returns 1 time unit after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_words", words_loaded, 0);
    @(negedge clk);
    rst = 1'b0;

    // Valid 2-word frame
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00);
    check("f1_no_early_we", imem_we, 0);
    send_byte(8'h20);
    check("f1_we0", imem_we, 1);
    check("f1_addr0", imem_addr, 0);
    check("f1_data0", imem_wdata, 32'h2000_0013);
    check("f1_words1", words_loaded, 1);
    send_byte(8'h08);
    check("f1_we_pulse", imem_we, 0);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
    check("f1_we1", imem_we, 1);
    check("f1_addr1", imem_addr, 1);
    check("f1_data1", imem_wdata, 32'h0800_0008);
    check("f1_words2", words_loaded, 2);
    check("f1_not_done_yet", done, 0);
    send_byte(8'h33);
    check("f1_done", done, 1);
    check("f1_cpu_rst", cpu_rst, 0);
    check("f1_in_ready", in_ready, 0);
    check("f1_error", error, 0);
    check("f1_we_count", we_count, 2);

    // Same frame with a bad checksum
    pulse_reset();
    check("f2_cpu_rst_after_rst", cpu_rst, 1);
    we_base = we_count;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
    send_byte(8'h08); send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
    send_byte(8'hFF);
    check("f2_error", error, 1);
    check("f2_cpu_rst", cpu_rst, 1);
    check("f2_done", done, 0);
    check("f2_in_ready", in_ready, 1);
    check("f2_writes", we_count - we_base, 2);

    // Resync from ERROR; data contains the sync value as payload
    send_byte(8'h00);
    check("f3_error_held", error, 1);
    send_byte(8'hA5);
    check("f3_error_clr", error, 0);
    check("f3_words_clr", words_loaded, 0);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hA5); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    check("f3_we", imem_we, 1);
    check("f3_addr", imem_addr, 0);
    check("f3_data", imem_wdata, 32'h1234_56A5);
    send_byte(8'hD5);
    check("f3_done", done, 1);
    check("f3_cpu_rst", cpu_rst, 0);

    // Zero-length image
    pulse_reset();
    we_base = we_count;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    check("f4_not_done", done, 0);
    send_byte(8'h00);
    check("f4_done", done, 1);
    check("f4_error", error, 0);
    check("f4_no_writes", we_count - we_base, 0);

    // Oversize length 1025
    pulse_reset();
    we_base = we_count;
    send_byte(8'hA5); send_byte(8'h01);
    check("f5_no_error_yet", error, 0);
    send_byte(8'h04);
    check("f5_error", error, 1);
    check("f5_done", done, 0);
    send_byte(8'h00);
    check("f5_no_writes", we_count - we_base, 0);

    // Reset mid-word, then a fresh valid frame
    pulse_reset();
    we_base = we_count;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    pulse_reset();
    check("f6_in_ready", in_ready, 1);
    check("f6_words", words_loaded, 0);
    check("f6_no_partial_write", we_count - we_base, 0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    check("f6_we", imem_we, 1);
    check("f6_addr", imem_addr, 0);
    check("f6_data", imem_wdata, 32'hDEAD_BEEF);
    send_byte(8'h22);
    check("f6_done", done, 1);
    check("f6_writes", we_count - we_base, 1);

`ifdef BOOT_TIMEOUT_EN
    // Inter-byte timeout with TIMEOUT_CYCLES=16
    pulse_reset();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    repeat (15) @(posedge clk);
    #1;
    check("tmo_not_yet", error, 0);
    @(posedge clk);
    #1;
    check("tmo_error", error, 1);
    check("tmo_cpu_rst", cpu_rst, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
